// File: rtl/branch_predictor.sv
// branch_predictor: 16-entry direct-mapped branch target buffer with 2-bit
// saturating counters. Lookup is combinational; updates commit at the clock edge.
// Optional statistics counters (stat_updates / stat_mispredicts) are built
// only when the macro BP_STATS_EN is defined.
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        bp_clear,
  output logic        mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 16;

  // Saturating increment of a 2-bit counter
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      return 2'b11;
    end else begin
      return c + 2'b01;
    end
  endfunction

  // Saturating decrement of a 2-bit counter
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      return 2'b00;
    end else begin
      return c - 2'b01;
    end
  endfunction

  logic        valid_q  [ENTRIES];
  logic        valid_d  [ENTRIES];
  logic [25:0] tag_q    [ENTRIES];
  logic [25:0] tag_d    [ENTRIES];
  logic [31:0] target_q [ENTRIES];
  logic [31:0] target_d [ENTRIES];
  logic [1:0]  ctr_q    [ENTRIES];
  logic [1:0]  ctr_d    [ENTRIES];

  logic [3:0]  fetch_idx_s;
  logic [25:0] fetch_tag_s;
  logic        fetch_hit_s;
  logic [3:0]  upd_idx_s;
  logic [25:0] upd_tag_s;
  logic        upd_hit_s;
  logic        unused_pc_bits_s;

  // Byte offset bits never participate in index or tag
  assign unused_pc_bits_s = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx_s = fetch_pc[5:2];
  assign fetch_tag_s = fetch_pc[31:6];
  assign upd_idx_s   = upd_pc[5:2];
  assign upd_tag_s   = upd_pc[31:6];

  // Zero-latency lookup of the fetch PC against the current table contents
  always_comb begin
    fetch_hit_s = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
    pred_taken  = fetch_hit_s && ctr_q[fetch_idx_s][1];
    if (pred_taken) begin
      pred_target = target_q[fetch_idx_s];
    end else begin
      pred_target = fetch_pc + 32'd4;
    end
  end

  // Compare resolved outcome against the prediction carried down the pipe
  always_comb begin
    upd_hit_s  = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
  end

  // Next-state of the table: clear wins over update; not-taken misses are ignored
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit_s) begin
        if (upd_taken) begin
          ctr_d[upd_idx_s]    = ctr_inc(ctr_q[upd_idx_s]);
          target_d[upd_idx_s] = upd_target;
        end else begin
          ctr_d[upd_idx_s] = ctr_dec(ctr_q[upd_idx_s]);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx_s]  = 1'b1;
        tag_d[upd_idx_s]    = upd_tag_s;
        target_d[upd_idx_s] = upd_target;
        ctr_d[upd_idx_s]    = 2'b10;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Table state; reset drops anything pending in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= 26'd0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_updates_q;
  logic [31:0] stat_updates_d;
  logic [31:0] stat_mispredicts_q;
  logic [31:0] stat_mispredicts_d;

  // Saturating event counters, independent of bp_clear
  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid && (stat_updates_q != 32'hFFFF_FFFF)) begin
      stat_updates_d = stat_updates_q + 32'd1;
    end else begin
      stat_updates_d = stat_updates_q;
    end
    if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end else begin
      stat_mispredicts_d = stat_mispredicts_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_q     <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
// Stats checks are compiled in only when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        bp_clear;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int passes = 0;

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .bp_clear        (bp_clear),
    .mispredict      (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        clr;
    logic        ept;
    logic [31:0] etgt;
    logic        emp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [31:0] fpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt, input logic clr,
                         input logic ept, input logic [31:0] etgt, input logic emp);
    vec_t v;
    v.name = name; v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.clr = clr;
    v.ept = ept; v.etgt = etgt; v.emp = emp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic check_lookup(input string name, input logic ept,
                              input logic [31:0] etgt, input logic emp);
    check({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, ept});
    check({name, ".pred_target"}, pred_target, etgt);
    check({name, ".mispredict"}, {31'd0, mispredict}, {31'd0, emp});
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'd0; bp_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    fetch_pc = 32'h0000_0100;
    idle_inputs();

    // Reset state with a taken update pending: lookup cold, mispredict still live
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h0000_0300; upd_taken = 1'b1;
    upd_target = 32'h0000_0500; upd_pred_taken = 1'b0; upd_pred_target = 32'h0000_0304;
    #1 check_lookup("reset_cold", 1'b0, 32'h0000_0104, 1'b1);

    // Edge during reset must not commit the update
    @(negedge clk);
    fetch_pc = 32'h0000_0300;
    #1 check_lookup("reset_discard", 1'b0, 32'h0000_0304, 1'b1);

    // First edge after deassertion accepts the update
    rst_n = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 check_lookup("first_edge_update", 1'b1, 32'h0000_0500, 1'b0);

    // Mid-operation async reset clears the table immediately and drops the pending update
    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h0000_0340; upd_taken = 1'b1;
    upd_target = 32'h0000_0600; upd_pred_taken = 1'b1; upd_pred_target = 32'h0000_0600;
    #1 check_lookup("async_reset_clear", 1'b0, 32'h0000_0304, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    fetch_pc = 32'h0000_0340;
    #1 check_lookup("reset_drop_pending", 1'b0, 32'h0000_0344, 1'b0);

    //       name          fetch         uv upc           ut utgt          upt uptgt         clr ept etgt          emp
    add_vec("cold",        32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h104,       0);
    add_vec("alloc",       32'h100,      1, 32'h100,      1, 32'h80,       0, 32'h104,      0,  0, 32'h104,       1);
    add_vec("hit_nt1",     32'h100,      1, 32'h100,      0, 32'h0,        1, 32'h80,       0,  1, 32'h80,        1);
    add_vec("hit_nt2",     32'h100,      1, 32'h100,      0, 32'h0,        0, 32'h104,      0,  0, 32'h104,       0);
    add_vec("hit_t_from0", 32'h100,      1, 32'h100,      1, 32'h80,       0, 32'h104,      0,  0, 32'h104,       1);
    add_vec("ctr01_nt",    32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h104,       0);
    add_vec("hit_t_new",   32'h100,      1, 32'h100,      1, 32'h90,       0, 32'h104,      0,  0, 32'h104,       1);
    add_vec("retarget",    32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h90,        0);
    add_vec("to_ctr11",    32'h100,      1, 32'h100,      1, 32'h90,       1, 32'h90,       0,  1, 32'h90,        0);
    add_vec("tgt_mispred", 32'h100,      1, 32'h100,      1, 32'h90,       1, 32'h94,       0,  1, 32'h90,        1);
    add_vec("dec_from11",  32'h100,      1, 32'h100,      0, 32'h0,        1, 32'h90,       0,  1, 32'h90,        1);
    add_vec("ctr10_taken", 32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h90,        0);
    add_vec("alias_alloc", 32'h1100,     1, 32'h1100,     1, 32'h2000,     0, 32'h1104,     0,  0, 32'h1104,      1);
    add_vec("alias_miss",  32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h104,       0);
    add_vec("alias_hit",   32'h1100,     0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h2000,      0);
    add_vec("low_bits",    32'h1102,     0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h2000,      0);
    add_vec("miss_nt",     32'h1100,     1, 32'h240,      0, 32'h0,        0, 32'h244,      0,  1, 32'h2000,      0);
    add_vec("miss_nt_no",  32'h240,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h244,       0);
    add_vec("miss_nt_keep",32'h1100,     0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h2000,      0);
    add_vec("pc_wrap",     32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h0,         0);
    add_vec("clear_upd",   32'h200,      1, 32'h200,      1, 32'h400,      0, 32'h204,      1,  0, 32'h204,       1);
    add_vec("clear_prio",  32'h200,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h204,       0);
    add_vec("clear_all",   32'h1100,     0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h1104,      0);
    add_vec("mp_gated",    32'h1100,     0, 32'h0,        1, 32'h40,       0, 32'h0,        0,  0, 32'h1104,      0);

    // Apply each vector away from the edge, check, then let the next edge commit it
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      fetch_pc        = vecs[i].fpc;
      upd_valid       = vecs[i].uv;
      upd_pc          = vecs[i].upc;
      upd_taken       = vecs[i].ut;
      upd_target      = vecs[i].utgt;
      upd_pred_taken  = vecs[i].upt;
      upd_pred_target = vecs[i].uptgt;
      bp_clear        = vecs[i].clr;
      #1 check_lookup(vecs[i].name, vecs[i].ept, vecs[i].etgt, vecs[i].emp);
    end

    @(negedge clk);
    idle_inputs();
`ifdef BP_STATS_EN
    // 11 valid updates and 8 mispredicts since the last reset, clear included
    #1;
    check("stat_updates", stat_updates, 32'd11);
    check("stat_mispredicts", stat_mispredicts, 32'd8);
    bp_clear = 1'b1;
    @(negedge clk);
    bp_clear = 1'b0;
    #1;
    check("stat_updates_after_clear", stat_updates, 32'd11);
    check("stat_mispredicts_after_clear", stat_mispredicts, 32'd8);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
